// File: rtl/multicycle_control.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXECUTE/MEM/WB with a one-cycle TRAP state.
// Handles imem/dmem handshakes, ack timeouts, illegal-opcode traps and the instret counter.
module multicycle_control #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [6:0]  i_opcode,
  input  logic        i_br_taken,
  input  logic        i_imem_ack,
  input  logic        i_dmem_ack,
  output logic        o_imem_req,
  output logic        o_mem_read,
  output logic        o_mem_write,
  output logic        o_ir_load,
  output logic        o_pc_write,
  output logic [1:0]  o_pc_src,
  output logic        o_alu_src_imm,
  output logic        o_reg_write,
  output logic [1:0]  o_wb_sel,
  output logic        o_illegal_instr,
  output logic        o_mem_fault,
  output logic [31:0] o_instret,
  output logic [2:0]  o_state
);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_TRAP    = 3'd5
  } state_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam int WW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_TIMEOUT - 1);

  state_t          r_state;
  state_t          w_next;
  logic [6:0]      r_opc;
  logic            r_cause_fault;
  logic [WW-1:0]   r_wait;
  logic [31:0]     r_instret;
  logic            w_legal;
  logic            w_waiting;
  logic            w_timeout;
  logic            w_retire;

  always_comb begin
    case (i_opcode)
      OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH,
      OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC: w_legal = 1'b1;
      default:                               w_legal = 1'b0;
    endcase
  end

  assign w_waiting = ((r_state == S_FETCH) && !i_imem_ack) ||
                     ((r_state == S_MEM) && !i_dmem_ack);
  assign w_timeout = w_waiting && (r_wait == WAIT_LAST);
  assign w_retire  = ((r_state == S_EXECUTE) && (r_opc == OPC_BRANCH)) ||
                     ((r_state == S_MEM) && (r_opc == OPC_STORE) && i_dmem_ack) ||
                     (r_state == S_WB);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH: begin
        if (i_imem_ack)     w_next = S_DECODE;
        else if (w_timeout) w_next = S_TRAP;
      end
      S_DECODE:  w_next = w_legal ? S_EXECUTE : S_TRAP;
      S_EXECUTE: begin
        if ((r_opc == OPC_LOAD) || (r_opc == OPC_STORE)) w_next = S_MEM;
        else if (r_opc == OPC_BRANCH)                    w_next = S_FETCH;
        else                                             w_next = S_WB;
      end
      S_MEM: begin
        if (i_dmem_ack)     w_next = (r_opc == OPC_LOAD) ? S_WB : S_FETCH;
        else if (w_timeout) w_next = S_TRAP;
      end
      S_WB:    w_next = S_FETCH;
      S_TRAP:  w_next = S_FETCH;
      default: w_next = S_FETCH;
    endcase
  end

  // Wait counter restarts on every state change so FETCH and MEM each get a full budget.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_opc         <= '0;
      r_cause_fault <= 1'b0;
      r_wait        <= '0;
      r_instret     <= '0;
    end else begin
      if (r_state == S_DECODE) r_opc <= i_opcode;
      if ((r_state == S_DECODE) && !w_legal) r_cause_fault <= 1'b0;
      else if (w_timeout)                    r_cause_fault <= 1'b1;
      if (w_next != r_state) r_wait <= '0;
      else if (w_waiting)    r_wait <= r_wait + 1'b1;
      if (w_retire) r_instret <= r_instret + 32'd1;
    end
  end

  always_comb begin
    o_imem_req      = 1'b0;
    o_mem_read      = 1'b0;
    o_mem_write     = 1'b0;
    o_ir_load       = 1'b0;
    o_pc_write      = 1'b0;
    o_pc_src        = 2'b00;
    o_alu_src_imm   = 1'b0;
    o_reg_write     = 1'b0;
    o_wb_sel        = 2'b00;
    o_illegal_instr = 1'b0;
    o_mem_fault     = 1'b0;
    if (!i_rst) begin
      case (r_state)
        S_FETCH: begin
          o_imem_req = 1'b1;
          o_ir_load  = i_imem_ack;
        end
        S_EXECUTE: begin
          o_alu_src_imm = (r_opc == OPC_OP_IMM) || (r_opc == OPC_LOAD) ||
                          (r_opc == OPC_STORE)  || (r_opc == OPC_JALR);
          if (r_opc == OPC_BRANCH) begin
            o_pc_write = 1'b1;
            o_pc_src   = {1'b0, i_br_taken};
          end
        end
        S_MEM: begin
          o_mem_read  = (r_opc == OPC_LOAD);
          o_mem_write = (r_opc == OPC_STORE);
          o_pc_write  = (r_opc == OPC_STORE) && i_dmem_ack;
        end
        S_WB: begin
          o_reg_write = 1'b1;
          o_pc_write  = 1'b1;
          case (r_opc)
            OPC_LOAD:          o_wb_sel = 2'b01;
            OPC_JAL, OPC_JALR: o_wb_sel = 2'b10;
            OPC_LUI:           o_wb_sel = 2'b11;
            default:           o_wb_sel = 2'b00;
          endcase
          if (r_opc == OPC_JAL)       o_pc_src = 2'b01;
          else if (r_opc == OPC_JALR) o_pc_src = 2'b10;
        end
        S_TRAP: begin
          o_pc_write      = 1'b1;
          o_pc_src        = 2'b11;
          o_illegal_instr = !r_cause_fault;
          o_mem_fault     = r_cause_fault;
        end
        default: ;
      endcase
    end
  end

  assign o_instret = r_instret;
  assign o_state   = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-instruction reference model walks each phase and checks
// every output on every cycle, with random opcodes, ack delays and ignored-input noise.
module tb_multicycle_control;
  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  opcode;
  logic        br_taken, imem_ack, dmem_ack;
  logic        imem_req, mem_read, mem_write, ir_load, pc_write, alu_src_imm, reg_write;
  logic        illegal_instr, mem_fault;
  logic [1:0]  pc_src, wb_sel;
  logic [31:0] instret;
  logic [2:0]  state;
  logic [15:0] obs;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_instret = '0;

  always #5 clk = ~clk;

  multicycle_control #(.MEM_TIMEOUT(T)) dut (
    .i_clk(clk), .i_rst(rst), .i_opcode(opcode), .i_br_taken(br_taken),
    .i_imem_ack(imem_ack), .i_dmem_ack(dmem_ack),
    .o_imem_req(imem_req), .o_mem_read(mem_read), .o_mem_write(mem_write),
    .o_ir_load(ir_load), .o_pc_write(pc_write), .o_pc_src(pc_src),
    .o_alu_src_imm(alu_src_imm), .o_reg_write(reg_write), .o_wb_sel(wb_sel),
    .o_illegal_instr(illegal_instr), .o_mem_fault(mem_fault),
    .o_instret(instret), .o_state(state)
  );

  assign obs = {state, imem_req, mem_read, mem_write, ir_load, pc_write, pc_src,
                alu_src_imm, reg_write, wb_sel, illegal_instr, mem_fault};

  function automatic logic [15:0] ev(input logic [2:0] st, input logic ireq, input logic rd,
                                     input logic wr, input logic irl, input logic pcw,
                                     input logic [1:0] pcs, input logic alu, input logic rw,
                                     input logic [1:0] wbs, input logic ill, input logic flt);
    return {st, ireq, rd, wr, irl, pcw, pcs, alu, rw, wbs, ill, flt};
  endfunction

  task automatic chk(input string tag, input logic [15:0] e);
    n_checks++;
    assert (obs === e) else begin
      n_fail++;
      $error("FAIL %s outputs observed=%h expected=%h", tag, obs, e);
    end
    n_checks++;
    assert (instret === exp_instret) else begin
      n_fail++;
      $error("FAIL %s instret observed=%0d expected=%0d", tag, instret, exp_instret);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic trap(input logic fault);
    opcode = 7'($urandom); br_taken = 1'($urandom);
    imem_ack = 1'($urandom); dmem_ack = 1'($urandom);
    #2;
    chk(fault ? "trap_fault" : "trap_illegal",
        ev(3'd5, 0, 0, 0, 0, 1, 2'b11, 0, 0, 2'b00, !fault, fault));
    step();
  endtask

  // One instruction through the reference: fd/md = cycles before imem/dmem ack.
  task automatic run_instr(input logic [6:0] opc, input logic br, input int fd, input int md);
    logic legal, ld, st, bra, alu, got, a;
    logic [1:0] wbs, pcs;
    legal = 1; ld = 0; st = 0; bra = 0; alu = 0; wbs = 2'b00; pcs = 2'b00;
    case (opc)
      7'b0110011: ;
      7'b0010011: alu = 1;
      7'b0000011: begin ld = 1; alu = 1; wbs = 2'b01; end
      7'b0100011: begin st = 1; alu = 1; end
      7'b1100011: bra = 1;
      7'b1101111: begin wbs = 2'b10; pcs = 2'b01; end
      7'b1100111: begin wbs = 2'b10; pcs = 2'b10; alu = 1; end
      7'b0110111: wbs = 2'b11;
      7'b0010111: ;
      default:    legal = 0;
    endcase

    got = 0;
    for (int k = 0; k < T; k++) begin
      a = (k == fd);
      imem_ack = a; dmem_ack = 1'($urandom);
      opcode = 7'($urandom); br_taken = 1'($urandom);
      #2;
      chk("fetch", ev(3'd0, 1, 0, 0, a, 0, 2'b00, 0, 0, 2'b00, 0, 0));
      step();
      if (a) begin got = 1; break; end
    end
    if (!got) begin trap(1); return; end

    opcode = opc; imem_ack = 1'($urandom); dmem_ack = 1'($urandom); br_taken = 1'($urandom);
    #2;
    chk("decode", ev(3'd1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0));
    step();
    if (!legal) begin trap(0); return; end

    opcode = 7'($urandom); br_taken = br;
    imem_ack = 1'($urandom); dmem_ack = 1'($urandom);
    #2;
    chk("execute", ev(3'd2, 0, 0, 0, 0, bra, bra ? {1'b0, br} : 2'b00, alu, 0, 2'b00, 0, 0));
    step();
    if (bra) begin exp_instret++; return; end

    if (ld || st) begin
      got = 0;
      for (int k = 0; k < T; k++) begin
        a = (k == md);
        dmem_ack = a; imem_ack = 1'($urandom);
        opcode = 7'($urandom); br_taken = 1'($urandom);
        #2;
        chk("mem", ev(3'd3, 0, ld, st, 0, st & a, 2'b00, 0, 0, 2'b00, 0, 0));
        step();
        if (a) begin got = 1; break; end
      end
      if (!got) begin trap(1); return; end
      if (st) begin exp_instret++; return; end
    end

    opcode = 7'($urandom); br_taken = 1'($urandom);
    imem_ack = 1'($urandom); dmem_ack = 1'($urandom);
    #2;
    chk("wb", ev(3'd4, 0, 0, 0, 0, 1, pcs, 0, 1, wbs, 0, 0));
    step();
    exp_instret++;
  endtask

  logic [6:0] legal_ops [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                                7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};

  initial begin
    logic [6:0] op;
    int fd, md;
    rst = 1; opcode = 7'b0110011; br_taken = 1; imem_ack = 1; dmem_ack = 1;
    step(); step();
    chk("reset", 16'h0000);
    rst = 0;
    exp_instret = '0;

    run_instr(7'b0110011, 0, 0, 0);
    run_instr(7'b0000011, 0, 0, 3);
    run_instr(7'b1100011, 1, 0, 0);
    run_instr(7'b1100011, 0, 0, 0);
    run_instr(7'b0000000, 0, 0, 0);
    run_instr(7'b1110011, 0, 0, 0);
    run_instr(7'b0110011, 0, T, 0);
    run_instr(7'b0110011, 0, T - 1, 0);
    run_instr(7'b0100011, 0, 1, T);
    run_instr(7'b0100011, 0, 0, T - 1);
    run_instr(7'b0000011, 0, 2, T);
    run_instr(7'b1101111, 0, 0, 0);
    run_instr(7'b1100111, 0, 1, 0);
    run_instr(7'b0110111, 0, 0, 0);
    run_instr(7'b0010111, 0, 0, 0);
    run_instr(7'b0010011, 0, 2, 0);
    run_instr(7'b0100011, 0, 0, 0);

    for (int i = 0; i < 80; i++) begin
      op = ($urandom_range(0, 4) == 0) ? 7'($urandom) : legal_ops[$urandom_range(0, 8)];
      fd = ($urandom_range(0, 9) == 0) ? T : $urandom_range(0, T - 1);
      md = ($urandom_range(0, 9) == 0) ? T : $urandom_range(0, T - 1);
      run_instr(op, 1'($urandom), fd, md);
    end

    // Reset asserted in the middle of a stalled STORE.
    imem_ack = 1; dmem_ack = 0; opcode = 7'($urandom);
    #2; chk("rst_seq_fetch", ev(3'd0, 1, 0, 0, 1, 0, 2'b00, 0, 0, 2'b00, 0, 0)); step();
    opcode = 7'b0100011; imem_ack = 0;
    #2; chk("rst_seq_decode", ev(3'd1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0)); step();
    opcode = 7'($urandom);
    #2; chk("rst_seq_exec", ev(3'd2, 0, 0, 0, 0, 0, 2'b00, 1, 0, 2'b00, 0, 0)); step();
    dmem_ack = 0;
    #2; chk("rst_seq_mem", ev(3'd3, 0, 0, 1, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0));
    #1; rst = 1; #1;
    exp_instret = '0;
    chk("rst_async", 16'h0000);
    step();
    chk("rst_held", 16'h0000);
    rst = 0;
    run_instr(7'b0110011, 0, 1, 0);
    run_instr(7'b0100011, 0, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
